response_return_arbiter: RTL

Per-master return-path arbiter for the crossbar. It picks one slave return FIFO whose head entry is addressed to this master, pops it, and pushes the entry into the master's return FIFO. It uses a grant-based rotating round-robin pointer. With burst locking enabled, the grant is held on one slave until that slave's last beat, so multi-beat read bursts reach the master unbroken. One instance sits per master port, between the slave return FIFOs and the master return FIFO.

---
 rtl/response_return_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/response_return_arbiter.sv
// Per-master return-path arbiter: picks a slave return FIFO whose head targets this master
// and moves that entry into the master return FIFO, optionally holding the grant for a whole burst.
module response_return_arbiter #(
    parameter int MASTERS            = 2,
    parameter int SLAVES             = 2,
    parameter int I_AM_MASTER_NUMBER = 0,
    parameter int LOCK_BURST         = 1,
    parameter int BEAT_W             = 8,
    localparam int DEST_W = (MASTERS > 1) ? $clog2(MASTERS) : 1,
    localparam int SEL_W  = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [SLAVES-1:0]         slave_fifo_empty,
    input  logic [SLAVES*DEST_W-1:0]  slave_master_dest,
    input  logic [SLAVES-1:0]         slave_last,
    input  logic                      master_fifo_full,
    output logic [SLAVES-1:0]         slave_pop,
    output logic                      push_to_fifo,
    output logic [SEL_W-1:0]          grant_slave_number,
    output logic                      locked,
    output logic [BEAT_W-1:0]         burst_beats
);

    localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(SLAVES - 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;
    localparam logic [DEST_W-1:0] MY_ID    = DEST_W'(I_AM_MASTER_NUMBER);
    localparam logic [SLAVES-1:0] ONE_HOT0 = {{(SLAVES-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]    lock_slave_q, lock_slave_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SLAVES-1:0]   req;
    logic [SEL_W-1:0]    grant_idx;
    logic                grant_valid;
    logic                grant_last;
    logic                fire;
    int                  cand;

    always_comb begin
        req = '0;
        for (int i = 0; i < SLAVES; i++) begin
            req[i] = ~slave_fifo_empty[i] & (slave_master_dest[i*DEST_W +: DEST_W] == MY_ID);
        end
    end

    // While locked only the burst owner may win, even if it is momentarily empty.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        if (state_q == LOCKED) begin
            grant_valid = req[lock_slave_q];
            grant_idx   = lock_slave_q;
        end else begin
            for (int k = 0; k < SLAVES; k++) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= SLAVES) begin
                    cand = cand - SLAVES;
                end
                if (!grant_valid && req[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(cand);
                end
            end
        end
        grant_last = slave_last[grant_idx];
        fire       = grant_valid & ~master_fifo_full & ~ARESET;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_slave_q <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_slave_q <= lock_slave_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Priority only rotates when a burst (or single beat) actually completes.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_slave_d = lock_slave_q;
        beat_cnt_d   = beat_cnt_q;
        if (fire) begin
            if (LOCK_BURST == 0 || grant_last) begin
                state_d    = IDLE;
                rr_ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                beat_cnt_d = '0;
            end else begin
                state_d      = LOCKED;
                lock_slave_d = grant_idx;
                if (beat_cnt_q != BEAT_MAX) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        push_to_fifo       = fire;
        slave_pop          = fire ? (ONE_HOT0 << grant_idx) : '0;
        grant_slave_number = grant_valid ? grant_idx : '0;
        locked             = (state_q == LOCKED);
        burst_beats        = beat_cnt_q;
    end

endmodule
